round_tracker: RTL and testbench

- Game-progress stage directly upstream of the scoring logic.
- Counts how many sequences the player completes correctly and presents the 4-bit `round` value that the scoring block combines with level and map into `points`.
- Runs the play/win/lose state machine and requests each new sequence from the sequence generator.
- Ends the game on error, on inactivity timeout, or on reaching the maximum round.

---
 rtl/round_tracker_pkg.sv | 15 +
 rtl/round_tracker_timer.sv | 31 +++
 rtl/round_tracker.sv | 138 +++++++++++++
 tb/tb_round_tracker.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/round_tracker_pkg.sv
// Shared definitions for the round tracker and the scoring block.
// The state encoding below is fixed so that other blocks can decode it.
package round_tracker_pkg;

  // Width of the round value that is passed to the scoring block.
  localparam int ROUND_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_WIN  = 2'd2,
    ST_LOSE = 2'd3
  } state_t;

endpackage

// File: rtl/round_tracker_timer.sv
// round_timeout_timer: an inactivity counter that can be cleared and enabled.
// While enable is high the counter counts up by one each cycle.
// expired goes high when the count reaches P_TIMEOUT-1.
// clear takes priority over enable.
module round_timeout_timer #(
  parameter int P_TIMEOUT = 50_000_000,
  parameter int P_TMR_W   = 26
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [P_TMR_W-1:0] count;

  // Count up while enabled; return to zero whenever a new sequence is requested.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == P_TMR_W'(P_TIMEOUT - 1));

endmodule

// File: rtl/round_tracker.sv
// round_tracker: runs the play/win/lose state machine and counts the rounds
// the player has completed. It also asks the sequence generator for each new
// sequence.
// Optional feature macro: ROUND_LEVEL_TARGET_EN. When it is defined, the win
// target is chosen by a 2-bit level that is sampled when the game starts.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | after reset; waiting for start
// PLAY    | a game is running; waiting for seq_done, seq_error or timeout
// WIN     | the win target was reached; round is frozen
// LOSE    | a wrong input or a timeout ended the game; round is frozen
module round_tracker
  import round_tracker_pkg::*;
#(
  parameter int P_ROUND_W   = ROUND_W,
  parameter int P_MAX_ROUND = 15,
  parameter int P_TIMEOUT   = 50_000_000,
  parameter int P_TMR_W     = 26
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 seq_done,
  input  logic                 seq_error,
`ifdef ROUND_LEVEL_TARGET_EN
  input  logic [1:0]           reg_setup_level,
`endif
  output logic                 new_seq,
  output logic [P_ROUND_W-1:0] round,
  output logic                 playing,
  output logic                 end_game,
  output logic                 win,
  output logic                 timeout
);

  state_t               state;
  logic [P_ROUND_W-1:0] round_inc;
  logic [P_ROUND_W-1:0] target;
  logic                 tmr_clear;
  logic                 tmr_enable;
  logic                 tmr_expired;

  assign round_inc = round + 1'b1;

`ifdef ROUND_LEVEL_TARGET_EN
  logic [1:0]           level_q;
  logic [P_ROUND_W-1:0] target_raw;

  // Capture the level when a game starts, so the target cannot change mid-game.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      level_q <= 2'd0;
    end else if (start && (state != ST_PLAY)) begin
      level_q <= reg_setup_level;
    end
  end

  assign target_raw = P_ROUND_W'(P_MAX_ROUND) >> (2'd3 - level_q);
  assign target     = (target_raw == '0) ? P_ROUND_W'(1) : target_raw;
`else
  assign target = P_ROUND_W'(P_MAX_ROUND);
`endif

  // The timer runs only in PLAY. It restarts each time a new sequence is requested.
  assign tmr_enable = (state == ST_PLAY);
  assign tmr_clear  = ((state != ST_PLAY) && start) ||
                      ((state == ST_PLAY) && seq_done && !seq_error);

  round_timeout_timer #(
    .P_TIMEOUT (P_TIMEOUT),
    .P_TMR_W   (P_TMR_W)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (tmr_clear),
    .enable  (tmr_enable),
    .expired (tmr_expired)
  );

  // Game FSM; the round counter and every output are registered here.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      round    <= '0;
      new_seq  <= 1'b0;
      playing  <= 1'b0;
      end_game <= 1'b0;
      win      <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      new_seq <= 1'b0;
      case (state)
        ST_IDLE, ST_WIN, ST_LOSE: begin
          if (start) begin
            state    <= ST_PLAY;
            round    <= '0;
            new_seq  <= 1'b1;
            playing  <= 1'b1;
            end_game <= 1'b0;
            win      <= 1'b0;
            timeout  <= 1'b0;
          end
        end
        ST_PLAY: begin
          if (seq_error) begin
            state    <= ST_LOSE;
            playing  <= 1'b0;
            end_game <= 1'b1;
            timeout  <= 1'b0;
          end else if (seq_done) begin
            if (round_inc == target) begin
              state    <= ST_WIN;
              round    <= target;
              playing  <= 1'b0;
              end_game <= 1'b1;
              win      <= 1'b1;
            end else begin
              round   <= round_inc;
              // A seq_done that arrives right after a request must not make
              // new_seq high for two cycles in a row.
              new_seq <= !new_seq;
            end
          end else if (tmr_expired) begin
            state    <= ST_LOSE;
            playing  <= 1'b0;
            end_game <= 1'b1;
            timeout  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_round_tracker.sv
// Directed bench for round_tracker.
// It uses P_MAX_ROUND=4 and P_TIMEOUT=20 so that the win and timeout
// corners can be reached in a short run.
module tb_round_tracker;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       seq_done = 1'b0;
  logic       seq_error = 1'b0;
  logic       new_seq;
  logic [3:0] round;
  logic       playing, end_game, win, timeout;
`ifdef ROUND_LEVEL_TARGET_EN
  logic [1:0] reg_setup_level = 2'd3;
`endif

  int checks = 0;
  int failures = 0;

  round_tracker #(
    .P_ROUND_W   (4),
    .P_MAX_ROUND (4),
    .P_TIMEOUT   (20),
    .P_TMR_W     (5)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .seq_done  (seq_done),
    .seq_error (seq_error),
`ifdef ROUND_LEVEL_TARGET_EN
    .reg_setup_level (reg_setup_level),
`endif
    .new_seq   (new_seq),
    .round     (round),
    .playing   (playing),
    .end_game  (end_game),
    .win       (win),
    .timeout   (timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit       s, d, e;
    bit       ns;
    bit [3:0] rnd;
    bit       pl, eg, w, to;
  } vec_t;

  vec_t vec [0:20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, and sample #1 after the edge.
  task automatic step(input bit s, input bit d, input bit e);
    start = s; seq_done = d; seq_error = e;
    @(posedge clock);
    #1;
    start = 1'b0; seq_done = 1'b0; seq_error = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [8:0] outs();
    return {new_seq, round, playing, end_game, win, timeout};
  endfunction

  initial begin
    int lose_cycle;
    int rnd_exp;
    bit ns_exp;

    //            s  d  e  ns rnd pl eg w  to
    vec[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    vec[1]  = '{1, 0, 0, 1, 0, 1, 0, 0, 0};
    vec[2]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
    vec[3]  = '{0, 1, 0, 1, 1, 1, 0, 0, 0};
    vec[4]  = '{0, 1, 0, 0, 2, 1, 0, 0, 0};
    vec[5]  = '{0, 0, 0, 0, 2, 1, 0, 0, 0};
    vec[6]  = '{0, 1, 1, 0, 2, 0, 1, 0, 0};
    vec[7]  = '{0, 1, 0, 0, 2, 0, 1, 0, 0};
    vec[8]  = '{1, 0, 0, 1, 0, 1, 0, 0, 0};
    vec[9]  = '{0, 0, 1, 0, 0, 0, 1, 0, 0};
    vec[10] = '{1, 0, 0, 1, 0, 1, 0, 0, 0};
    vec[11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
    vec[12] = '{0, 1, 0, 1, 1, 1, 0, 0, 0};
    vec[13] = '{0, 0, 0, 0, 1, 1, 0, 0, 0};
    vec[14] = '{0, 1, 0, 1, 2, 1, 0, 0, 0};
    vec[15] = '{0, 0, 0, 0, 2, 1, 0, 0, 0};
    vec[16] = '{0, 1, 0, 1, 3, 1, 0, 0, 0};
    vec[17] = '{0, 0, 0, 0, 3, 1, 0, 0, 0};
    vec[18] = '{0, 1, 0, 0, 4, 0, 1, 1, 0};
    vec[19] = '{0, 1, 0, 0, 4, 0, 1, 1, 0};
    vec[20] = '{1, 0, 0, 1, 0, 1, 0, 0, 0};

    // Check the state while reset is held, before the first clock edge.
    #2;
    check("reset_outs", 32'(outs()), 32'd0);
    do_reset();

    // Run the table of single-cycle vectors.
    for (int i = 0; i <= 20; i++) begin
      step(vec[i].s, vec[i].d, vec[i].e);
      check($sformatf("vec%0d", i), 32'(outs()),
            32'({vec[i].ns, vec[i].rnd, vec[i].pl, vec[i].eg, vec[i].w, vec[i].to}));
    end

    // Start, then seq_done at cycles 10, 20 and 30. Expect new_seq at cycles 1, 11, 21, 31.
    do_reset();
    rnd_exp = 0;
    for (int c = 0; c < 35; c++) begin
      step(c == 0, (c == 10) || (c == 20) || (c == 30), 1'b0);
      if ((c == 10) || (c == 20) || (c == 30)) rnd_exp++;
      ns_exp = ((c + 1) == 1) || ((c + 1) == 11) || ((c + 1) == 21) || ((c + 1) == 31);
      check($sformatf("spaced_ns_c%0d", c + 1), 32'(new_seq), 32'(ns_exp));
      check($sformatf("spaced_rnd_c%0d", c + 1), 32'(round), 32'(rnd_exp));
    end

    // Assert reset mid-game while round is 3. It must take effect without a clock edge.
    #2;
    reset = 1'b0;
    #1;
    check("midreset_outs", 32'(outs()), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step(0, 0, 0);
      check($sformatf("post_reset_c%0d", c), 32'(outs()), 32'd0);
    end

    // With no activity, the game should be lost by timeout 20 cycles after new_seq (cycle 21).
    step(1, 0, 0);
    lose_cycle = 0;
    for (int c = 1; c < 60; c++) begin
      step(0, 0, 0);
      if (!playing) begin
        lose_cycle = c + 1;
        break;
      end
    end
    check("timeout_cycle", 32'(lose_cycle), 32'd21);
    check("timeout_outs", 32'(outs()), 32'({1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1}));

    // A start pulse in LOSE should begin a new game and issue exactly one new_seq.
    step(1, 0, 0);
    check("restart_outs", 32'(outs()), 32'({1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0}));
    step(0, 0, 0);
    check("restart_ns_single", 32'(new_seq), 32'd0);

`ifdef ROUND_LEVEL_TARGET_EN
    // With level 1 the target is 4 >> 2 = 1, so the first seq_done wins the game.
    step(0, 0, 1);
    reg_setup_level = 2'd1;
    step(1, 0, 0);
    reg_setup_level = 2'd3;
    step(0, 0, 0);
    step(0, 1, 0);
    check("level1_win", 32'(outs()), 32'({1'b0, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0}));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
